qei_decoder: RTL and testbench
==============================

# qei_decoder

Quadrature encoder front end that sits between the `qei_a`/`qei_b`/`qei_i` pads and the QEI register bank of `top`. It synchronises and glitch-filters the three raw encoder lines and decodes the A/B Gray sequence into a signed position counter. It latches the position on an index pulse and counts illegal transitions. The register bank consumes `count`, `index_pos`, `index_valid` and `err_cnt` directly, with no further processing.

## Interface
- `CNT_W`, 32: position counter width, two's complement.
- `SYNC_STAGES`, 2: flip-flop synchroniser depth per input, ≥2.
- `FILT_LEN`, 3: consecutive equal synchronised samples required to accept a new level, ≥1.
- `sys_clk`  in  1: single clock; all logic on rising edge.
- `sys_rst`  in  1: synchronous, active-high reset.
- `qei_a`  in  1: raw encoder A, asynchronous.
- `qei_b`  in  1: raw encoder B, asynchronous.
- `qei_i`  in  1: raw encoder index, asynchronous.
- `clear`  in  1: one-cycle pulse; zero the position counter.
- `index_arm`  in  1: one-cycle pulse; arm the index capture and clear `index_valid`.
- `count`  out  CNT_W: signed position.
- `dir`  out  1: direction of the last valid step; 1 = up.
- `step`  out  1: one-cycle pulse on every valid count change.
- `index_pos`  out  CNT_W: position captured at the index edge.
- `index_valid`  out  1: `index_pos` holds a fresh capture.
- `err`  out  1: one-cycle pulse on an illegal transition.
- `err_cnt`  out  8: illegal transition count, saturating.

## Operation
- Reset values:
  - all outputs 0; internal state below is also 0.
  - synchroniser and filter state 0; previous AB state = 00; index capture disarmed.
- Synchroniser: a SYNC_STAGES-deep flip-flop chain per input.
- Filter, per channel:
  - a counter tracks how many consecutive synchronised samples differ from the filtered level;
  - the filtered level toggles on the cycle the FILT_LEN-th consecutive differing sample arrives;
  - any sample equal to the filtered level resets the counter to 0.
- Decode compares the filtered {A,B} with the previous {A,B} each cycle:
  - Up sequence 00→01→11→10→00: count+1, dir=1, step=1.
  - Reverse sequence: count−1, dir=0, step=1.
  - No change: hold.
  - Both bits changed: err=1, count and dir hold, err_cnt+1 saturating at 255.
  - The previous state always updates to the current state, including after an error.
- Counter arithmetic: modulo 2^CNT_W. Max positive +1 wraps to min negative; min negative −1 wraps to max positive.
- `clear` has priority over a same-cycle step:
  - count=0;
  - step, dir and err still report the decoded event;
  - err_cnt is unaffected by `clear`.
- Index capture:
  - `index_arm` sets armed=1 and index_valid=0.
  - A filtered qei_i rising edge while armed loads index_pos with the post-update count value (including any same-cycle step or clear), sets index_valid=1 and disarms.
  - Index edges while disarmed are ignored.
  - If `index_arm` and an index edge occur in the same cycle, arm wins: no capture, armed=1.

## Timing
- Latency, edge-to-count: the change appears on `count` after the (SYNC_STAGES+FILT_LEN+1)-th rising edge, counting the first edge that samples the new raw level. Defaults give 6.
- Index has the same latency to index_valid.
- `step` and `err` are asserted in the same cycle `count` and `err_cnt` update.
- Glitch rejection: a raw pulse shorter than FILT_LEN cycles, once synchronised, is never seen by the decoder.
- Maximum decodable rate: one filtered edge per FILT_LEN+1 cycles per channel.
- `clear` and `index_arm` take effect on the next edge; no handshake. Back-to-back pulses are each honoured.
- Reset mid-operation: everything returns to reset values on the reset edge. Decoding resumes from AB=00, so an encoder resting at 11 produces one err on release; this is required behaviour.

## Structure
- Package `qei_pkg`:
  - AB state constants;
  - a decode function mapping (prev,cur) to {up, down, illegal, none};
  - ERR_W=8 and the ERR_MAX constant.
- Sub-module `qei_filter` (params SYNC_STAGES, FILT_LEN; ports sys_clk, sys_rst, raw, filt). Instantiated three times.
- Top level holds the decode, counter, index and error logic.

## Test plan
- Forward: drive 8 up-steps, each held 10 cycles → count=8, dir=1, 8 step pulses; first change exactly 6 cycles after the first raw edge.
- Reverse wrap: from count=0, drive 1 down-step → count=2^32−1 (−1), dir=0; then 1 up-step → 0.
- Glitch: 2-cycle pulses on A, and separately on I → count, step and index_valid unchanged; a 3-cycle pulse is accepted.
- Illegal:
  - jump AB 00→11 → err pulse, err_cnt=1, count unchanged;
  - force 300 illegal jumps → err_cnt=255.
- Index:
  - pulse index_arm at count=5;
  - I rising edge while stepping up to 6 in the same cycle → index_pos=6, index_valid=1;
  - second I edge → index_pos stays 6.
- Priority and reset:
  - clear in the same cycle as an up-step → count=0, step=1;
  - sys_rst asserted mid-sequence at count=17 → all outputs 0 on the next edge.

Source files
------------

// File: rtl/qei_pkg.sv
// Shared definitions for the quadrature decoder: AB Gray states, error counter
// sizing and the (previous, current) AB transition classifier.
package qei_pkg;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_UP,
    DEC_DOWN,
    DEC_ILLEGAL
  } dec_e;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00; any single-bit move that is
  // not the forward successor must be the reverse one.
  function automatic dec_e qei_decode(input logic [1:0] prev, input logic [1:0] cur);
    dec_e d;
    logic up;
    d  = DEC_NONE;
    up = 1'b0;
    case (prev)
      AB_00:   up = (cur == AB_01);
      AB_01:   up = (cur == AB_11);
      AB_11:   up = (cur == AB_10);
      default: up = (cur == AB_00);
    endcase
    if (prev == cur) begin
      d = DEC_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      d = DEC_ILLEGAL;
    end else begin
      d = up ? DEC_UP : DEC_DOWN;
    end
    return d;
  endfunction

endpackage

// File: rtl/qei_filter.sv
// Per-line front end: flip-flop synchroniser followed by a run-length glitch
// filter that only accepts a new level after FILT_LEN consecutive samples.
module qei_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic raw,
  output logic filt
);

  localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_sample;

  assign w_sample = r_sync[SYNC_STAGES-1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
      // r_cnt holds how many differing samples preceded this one.
      if (w_sample == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT_LEN - 1)) begin
        r_filt <= ~r_filt;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign filt = r_filt;

endmodule

// File: rtl/qei_decoder.sv
// Quadrature encoder front end: filters A/B/I, decodes the Gray sequence into
// a signed position, captures position on an armed index edge, counts errors.
module qei_decoder
  import qei_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             qei_a,
  input  logic             qei_b,
  input  logic             qei_i,
  input  logic             clear,
  input  logic             index_arm,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic [CNT_W-1:0] index_pos,
  output logic             index_valid,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  logic [2:0]       w_raw;
  logic [2:0]       w_filt;
  logic [1:0]       w_ab;
  dec_e             w_dec;
  logic             w_i_rise;
  logic [CNT_W-1:0] w_count_next;

  logic [1:0]       r_prev_ab;
  logic             r_prev_i;
  logic [CNT_W-1:0] r_count;
  logic             r_dir;
  logic             r_step;
  logic             r_err;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_armed;
  logic [CNT_W-1:0] r_index_pos;
  logic             r_index_valid;

  assign w_raw = {qei_i, qei_b, qei_a};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_filt
      qei_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
      ) u_filt (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .raw    (w_raw[gi]),
        .filt   (w_filt[gi])
      );
    end
  endgenerate

  assign w_ab     = {w_filt[0], w_filt[1]};
  assign w_dec    = qei_decode(r_prev_ab, w_ab);
  assign w_i_rise = w_filt[2] & ~r_prev_i;

  // clear overrides the step; the index capture sees this post-update value.
  always_comb begin
    w_count_next = r_count;
    if (w_dec == DEC_UP) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_dec == DEC_DOWN) begin
      w_count_next = r_count - CNT_W'(1);
    end
    if (clear) begin
      w_count_next = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_prev_ab     <= AB_00;
      r_prev_i      <= 1'b0;
      r_count       <= '0;
      r_dir         <= 1'b0;
      r_step        <= 1'b0;
      r_err         <= 1'b0;
      r_err_cnt     <= '0;
      r_armed       <= 1'b0;
      r_index_pos   <= '0;
      r_index_valid <= 1'b0;
    end else begin
      r_prev_ab <= w_ab;
      r_prev_i  <= w_filt[2];
      r_count   <= w_count_next;
      r_step    <= (w_dec == DEC_UP) || (w_dec == DEC_DOWN);
      r_err     <= (w_dec == DEC_ILLEGAL);
      if (w_dec == DEC_UP) begin
        r_dir <= 1'b1;
      end else if (w_dec == DEC_DOWN) begin
        r_dir <= 1'b0;
      end
      if ((w_dec == DEC_ILLEGAL) && (r_err_cnt != ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
      // A same-cycle arm beats the index edge.
      if (index_arm) begin
        r_armed       <= 1'b1;
        r_index_valid <= 1'b0;
      end else if (r_armed && w_i_rise) begin
        r_index_pos   <= w_count_next;
        r_index_valid <= 1'b1;
        r_armed       <= 1'b0;
      end
    end
  end

  assign count       = r_count;
  assign dir         = r_dir;
  assign step        = r_step;
  assign err         = r_err;
  assign err_cnt     = r_err_cnt;
  assign index_pos   = r_index_pos;
  assign index_valid = r_index_valid;

endmodule

// File: tb/tb_qei_decoder.sv
// Scoreboard bench for qei_decoder: a Gray-position reference model predicts
// each step/err/index event and its arrival cycle; a monitor checks them.
module tb_qei_decoder;

  localparam int LAT = 6;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        qei_a = 1'b0, qei_b = 1'b0, qei_i = 1'b0;
  logic        clear = 1'b0, index_arm = 1'b0;
  logic [31:0] count, index_pos;
  logic        dir, step, index_valid, err;
  logic [7:0]  err_cnt;

  qei_decoder #(.CNT_W(32), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .qei_a      (qei_a),
    .qei_b      (qei_b),
    .qei_i      (qei_i),
    .clear      (clear),
    .index_arm  (index_arm),
    .count      (count),
    .dir        (dir),
    .step       (step),
    .index_pos  (index_pos),
    .index_valid(index_valid),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic        step;
    logic        err;
    logic        dir;
    logic        iv;
    logic [31:0] cnt;
    logic [31:0] ipos;
    logic [7:0]  errc;
  } exp_t;
  exp_t sb[$];

  // Reference model: position on the Gray circle 00,01,11,10.
  int          g_idx[4] = '{0, 1, 3, 2};
  logic [1:0]  g_ab[4]  = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0]  m_ab = 2'b00;
  logic        m_i = 1'b0;
  logic [31:0] m_count = '0;
  logic        m_dir = 1'b0;
  int          m_errc = 0;
  logic        m_armed = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_ipos = '0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic predict(input logic [1:0] ab, input logic i, input bit with_clr, input int stim);
    int   d;
    bit   st, er, cap;
    exp_t e;
    d  = (g_idx[ab] - g_idx[m_ab] + 4) % 4;
    st = (d == 1) || (d == 3);
    er = (d == 2);
    if (d == 1) begin
      m_count = m_count + 32'd1;
      m_dir   = 1'b1;
    end else if (d == 3) begin
      m_count = m_count - 32'd1;
      m_dir   = 1'b0;
    end else if (d == 2) begin
      if (m_errc < 255) m_errc++;
    end
    if (with_clr) m_count = '0;
    cap = i && !m_i && m_armed;
    if (cap) begin
      m_ipos  = m_count;
      m_valid = 1'b1;
      m_armed = 1'b0;
    end
    m_ab = ab;
    m_i  = i;
    if (st || er || cap) begin
      e.cyc  = stim + LAT;
      e.step = st;
      e.err  = er;
      e.dir  = m_dir;
      e.iv   = m_valid;
      e.cnt  = m_count;
      e.ipos = m_ipos;
      e.errc = 8'(m_errc);
      sb.push_back(e);
    end
  endtask

  task automatic move(input logic [1:0] ab, input logic i, input int hold, input bit with_clr);
    qei_a = ab[1];
    qei_b = ab[0];
    qei_i = i;
    predict(ab, i, with_clr, cyc);
    if (with_clr) begin
      repeat (LAT - 1) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (hold - LAT) tick();
    end else begin
      repeat (hold) tick();
    end
  endtask

  task automatic step_up(input int hold);
    move(g_ab[(g_idx[m_ab] + 1) % 4], m_i, hold, 1'b0);
  endtask

  task automatic step_dn(input int hold);
    move(g_ab[(g_idx[m_ab] + 3) % 4], m_i, hold, 1'b0);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_count = '0;
    tick();
  endtask

  task automatic arm_pulse();
    index_arm = 1'b1;
    tick();
    index_arm = 1'b0;
    m_armed = 1'b1;
    m_valid = 1'b0;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending_events=%0d required=0 (cyc %0d)", sb.size(), cyc);
      sb.delete();
    end
  endtask

  task automatic monitor();
    logic prev_iv;
    bit   trig;
    exp_t e;
    prev_iv = 1'b0;
    forever begin
      @(negedge sys_clk);
      trig    = !sys_rst && (step || err || (index_valid && !prev_iv));
      prev_iv = index_valid;
      if (trig) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_event cyc=%0d step=%0b err=%0b index_valid=%0b required no event",
                   cyc, step, err, index_valid);
        end else begin
          e = sb.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("count", count, e.cnt);
          chk("step", {31'd0, step}, {31'd0, e.step});
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("dir", {31'd0, dir}, {31'd0, e.dir});
          chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.errc});
          chk("index_valid", {31'd0, index_valid}, {31'd0, e.iv});
          chk("index_pos", index_pos, e.ipos);
          $display("txn cyc=%0d count=%0h step=%0b err=%0b dir=%0b err_cnt=%0d iv=%0b ipos=%0h",
                   cyc, count, step, err, dir, err_cnt, index_valid, index_pos);
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"}, count, 32'd0);
    chk({tag, "_index_pos"}, index_pos, 32'd0);
    chk({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
    chk({tag, "_flags"}, {28'd0, dir, step, index_valid, err}, 32'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) tick();
    chk_all_zero("reset");
    sys_rst = 1'b0;
    repeat (4) tick();

    // Forward: 8 up-steps
    for (int k = 0; k < 8; k++) step_up(10);
    drain();
    chk("fwd_count", count, 32'd8);
    chk("fwd_dir", {31'd0, dir}, 32'd1);

    // Reverse wrap through zero
    clear_pulse();
    chk("clear_quiet_count", count, 32'd0);
    step_dn(10);
    step_up(10);
    drain();

    // Glitches: 2-cycle pulses rejected, 3-cycle pulse accepted
    qei_a = 1'b1;
    repeat (2) tick();
    qei_a = 1'b0;
    repeat (10) tick();
    chk("glitch_a_count", count, m_count);
    arm_pulse();
    qei_i = 1'b1;
    repeat (2) tick();
    qei_i = 1'b0;
    repeat (10) tick();
    chk("glitch_i_valid", {31'd0, index_valid}, 32'd0);
    move(2'b10, 1'b0, 3, 1'b0);
    move(2'b00, 1'b0, 10, 1'b0);
    drain();

    // Illegal transitions and saturation
    move(2'b11, 1'b0, 10, 1'b0);
    drain();
    chk("illegal_err_cnt", {24'd0, err_cnt}, 32'd1);
    chk("illegal_count", count, m_count);
    for (int k = 0; k < 300; k++) move(m_ab ^ 2'b11, 1'b0, 5, 1'b0);
    drain();
    chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);

    // Index capture coincident with the step to 6
    while (m_count != 32'd5) step_up(8);
    drain();
    arm_pulse();
    move(g_ab[(g_idx[m_ab] + 1) % 4], 1'b1, 10, 1'b0);
    move(m_ab, 1'b0, 10, 1'b0);
    move(m_ab, 1'b1, 10, 1'b0);
    drain();
    chk("index_pos_hold", index_pos, 32'd6);
    chk("index_valid_hold", {31'd0, index_valid}, 32'd1);

    // clear coincident with an up-step
    move(g_ab[(g_idx[m_ab] + 1) % 4], m_i, 10, 1'b1);
    drain();

    // Reset mid-sequence at count 17; encoder left resting at 11
    clear_pulse();
    for (int k = 0; k < 17; k++) step_up(8);
    drain();
    chk("pre_reset_count", count, 32'd17);
    sys_rst = 1'b1;
    qei_a = 1'b1;
    qei_b = 1'b1;
    qei_i = 1'b0;
    tick();
    chk_all_zero("midreset");
    tick();
    sys_rst = 1'b0;
    m_ab = 2'b00; m_i = 1'b0; m_count = '0; m_dir = 1'b0; m_errc = 0;
    m_armed = 1'b0; m_valid = 1'b0; m_ipos = '0;
    predict(2'b11, 1'b0, 1'b0, cyc);
    repeat (10) tick();
    drain();
    chk("release_err_cnt", {24'd0, err_cnt}, 32'd1);

    // Randomized moves with occasional clear / arm in quiet periods
    for (int k = 0; k < 150; k++) begin
      int   r;
      logic [1:0] nab;
      logic       ni;
      r = int'($urandom_range(0, 9));
      if (r == 0) clear_pulse();
      else if (r == 1) arm_pulse();
      nab = 2'($urandom_range(0, 3));
      ni  = ($urandom_range(0, 2) == 0) ? ~m_i : m_i;
      move(nab, ni, int'($urandom_range(7, 10)), 1'b0);
    end
    drain();
    chk("final_count", count, m_count);
    chk("final_err_cnt", {24'd0, err_cnt}, 32'(m_errc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
